// File: rtl/ad7606_readout.sv
// ad7606_readout: reads one AD7606 conversion frame over the parallel bus
// after each BUSY falling edge and streams it bytewise (MSB first) into an aFifo.
//
// Parameters:
//   NUM_CH      channels read per conversion (1..8)
//   RD_LOW_CYC  clk_i cycles rd_o is held low per channel (>=1)
// Optional feature macro:
//   READOUT_PKT_HEADER_EN  prefix each frame with 0xA5 and an 8-bit sequence count
// Ports:
//   clk_i, reset_n_i            clock, async active-low reset
//   busy_i, frstdata_i, db_i    ADC status and data bus (busy_i asynchronous)
//   cs_o, rd_o                  ADC chip select / read strobe, active low
//   fifo_wrfull_i               downstream FIFO full
//   fifo_wrreq_o, fifo_data_o   byte write strobe and data
//   frame_done_o                pulse after a complete frame
//   overflow_o, err_frst_o      sticky truncation / FRSTDATA error flags
module ad7606_readout #(
  parameter int unsigned NUM_CH     = 8,
  parameter int unsigned RD_LOW_CYC = 2
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        busy_i,
  input  logic        frstdata_i,
  input  logic [15:0] db_i,
  output logic        cs_o,
  output logic        rd_o,
  input  logic        fifo_wrfull_i,
  output logic        fifo_wrreq_o,
  output logic [7:0]  fifo_data_o,
  output logic        frame_done_o,
  output logic        overflow_o,
  output logic        err_frst_o
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned RD_W = (RD_LOW_CYC > 1) ? $clog2(RD_LOW_CYC) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic [RD_W-1:0] LAST_RD = RD_W'(RD_LOW_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, HDR0, HDR1, RD_LO, WR_MSB, WR_LSB, DONE
  } state_t;

  state_t          state, state_nxt, target;
  logic [1:0]      sync_q;
  logic [1:0]      warm_q;
  logic            busy_hist;
  logic            busy_fall;
  logic [RD_W-1:0] rd_cnt;
  logic [CH_W-1:0] ch_cnt;
  logic [7:0]      lsb_q;
  logic            blocked;
  logic            cs_nxt, rd_nxt, wrreq_nxt, done_nxt;
  logic [7:0]      data_nxt;
`ifdef READOUT_PKT_HEADER_EN
  logic [7:0]      seq_q;
`endif

  // BUSY synchronizer and falling-edge detector. The synchronizer resets high;
  // warm_q keeps those reset-forced ones from looking like a falling edge when
  // reset is released while BUSY is already low.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync_q    <= 2'b11;
      warm_q    <= 2'b00;
      busy_hist <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], busy_i};
      warm_q    <= {warm_q[0], 1'b1};
      busy_hist <= sync_q[1] & warm_q[1];
    end
  end

  assign busy_fall = busy_hist & ~sync_q[1];

  // State register and registered outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state        <= IDLE;
      cs_o         <= 1'b1;
      rd_o         <= 1'b1;
      fifo_wrreq_o <= 1'b0;
      fifo_data_o  <= 8'h00;
      frame_done_o <= 1'b0;
    end else begin
      state        <= state_nxt;
      cs_o         <= cs_nxt;
      rd_o         <= rd_nxt;
      fifo_wrreq_o <= wrreq_nxt;
      fifo_data_o  <= data_nxt;
      frame_done_o <= done_nxt;
    end
  end

  // Next state; any move into a byte-writing state is diverted to DONE when
  // the FIFO is full, which truncates the frame.
  always_comb begin
    target = state;
    case (state)
`ifdef READOUT_PKT_HEADER_EN
      IDLE:   if (busy_fall) target = HDR0;
      HDR0:   target = HDR1;
      HDR1:   target = RD_LO;
`else
      IDLE:   if (busy_fall) target = RD_LO;
`endif
      RD_LO:  if (rd_cnt == LAST_RD) target = WR_MSB;
      WR_MSB: target = WR_LSB;
      WR_LSB: target = (ch_cnt == LAST_CH) ? DONE : RD_LO;
      DONE:   target = IDLE;
      default: target = IDLE;
    endcase
    blocked = fifo_wrfull_i &&
              (target == WR_MSB || target == WR_LSB || target == HDR0 || target == HDR1);
    state_nxt = blocked ? DONE : target;
  end

  // Output decode from the next state so the registered pins line up with it.
  always_comb begin
    cs_nxt    = 1'b1;
    rd_nxt    = 1'b1;
    wrreq_nxt = 1'b0;
    data_nxt  = fifo_data_o;
    done_nxt  = 1'b0;
    case (state_nxt)
      RD_LO: begin
        cs_nxt = 1'b0;
        rd_nxt = 1'b0;
      end
      WR_MSB: begin
        cs_nxt    = 1'b0;
        wrreq_nxt = 1'b1;
        data_nxt  = db_i[15:8];
      end
      WR_LSB: begin
        cs_nxt    = 1'b0;
        wrreq_nxt = 1'b1;
        data_nxt  = lsb_q;
      end
`ifdef READOUT_PKT_HEADER_EN
      HDR0: begin
        wrreq_nxt = 1'b1;
        data_nxt  = 8'hA5;
      end
      HDR1: begin
        wrreq_nxt = 1'b1;
        data_nxt  = seq_q;
      end
`endif
      // Only the last channel's LSB leads to DONE unblocked.
      DONE: done_nxt = (state == WR_LSB);
      default: ;
    endcase
  end

  // Datapath: strobe/channel counters, LSB latch, sticky flags, sequence count.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_cnt     <= '0;
      ch_cnt     <= '0;
      lsb_q      <= 8'h00;
      overflow_o <= 1'b0;
      err_frst_o <= 1'b0;
`ifdef READOUT_PKT_HEADER_EN
      seq_q      <= 8'h00;
`endif
    end else begin
      rd_cnt <= (state == RD_LO && state_nxt == RD_LO) ? rd_cnt + 1'b1 : '0;
      if (state == IDLE)
        ch_cnt <= '0;
      else if (state == WR_LSB)
        ch_cnt <= ch_cnt + 1'b1;
      if (state == RD_LO && state_nxt == WR_MSB)
        lsb_q <= db_i[7:0];
      if (blocked)
        overflow_o <= 1'b1;
      if (state == RD_LO && rd_cnt == LAST_RD && ch_cnt == '0 && !frstdata_i)
        err_frst_o <= 1'b1;
`ifdef READOUT_PKT_HEADER_EN
      if (state == HDR0 && state_nxt == HDR1)
        seq_q <= seq_q + 8'h01;
`endif
    end
  end

endmodule

// File: tb/tb_ad7606_readout.sv
// tb_ad7606_readout: randomized scoreboard bench for ad7606_readout.
// Expected bytes are queued per frame from the channel values; a negedge
// monitor pops and compares on every fifo_wrreq_o.
module tb_ad7606_readout;

  localparam int NUM_CH     = 8;
  localparam int RD_LOW_CYC = 2;
  localparam int FRAME_CYC  = NUM_CH * (RD_LOW_CYC + 2);
`ifdef READOUT_PKT_HEADER_EN
  localparam int HDR = 2;
`else
  localparam int HDR = 0;
`endif
  localparam int TOTAL = HDR + 2 * NUM_CH;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b1;
  logic        busy_i = 1'b1;
  logic        frstdata_i = 1'b0;
  logic [15:0] db_i = 16'h0000;
  logic        fifo_wrfull_i = 1'b0;
  logic        cs_o, rd_o, fifo_wrreq_o, frame_done_o, overflow_o, err_frst_o;
  logic [7:0]  fifo_data_o;

  always #5 clk_i = ~clk_i;

  ad7606_readout #(.NUM_CH(NUM_CH), .RD_LOW_CYC(RD_LOW_CYC)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .busy_i(busy_i), .frstdata_i(frstdata_i),
    .db_i(db_i), .cs_o(cs_o), .rd_o(rd_o), .fifo_wrfull_i(fifo_wrfull_i),
    .fifo_wrreq_o(fifo_wrreq_o), .fifo_data_o(fifo_data_o),
    .frame_done_o(frame_done_o), .overflow_o(overflow_o), .err_frst_o(err_frst_o)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] adc_val[NUM_CH];
  int          adc_idx = 0;
  bit          frst_bad = 1'b0;
  int          frame_wr_cnt = 0, done_cnt = 0, rd_cnt = 0, cyc = 0;
  int          cs_fall_cyc = -1, done_cyc = 0;
  logic        rd_prev = 1'b1, cs_prev = 1'b1;
  logic [7:0]  seq_m = 8'h00;
  bit          ovf_m = 1'b0, err_m = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h required %0h", name, got, exp);
    end
  endtask

  // ADC model: each RD falling edge puts the next channel on the bus.
  always @(negedge rd_o) begin
    if (adc_idx < NUM_CH) begin
      db_i       = adc_val[adc_idx];
      frstdata_i = (adc_idx == 0) && !frst_bad;
    end else begin
      db_i       = 16'hDEAD;
      frstdata_i = 1'b0;
    end
    adc_idx++;
  end

  // Monitor / scoreboard.
  always @(negedge clk_i) begin
    cyc++;
    if (fifo_wrreq_o === 1'b1) begin
      frame_wr_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write got %02h required no write", fifo_data_o);
      end else begin
        chk("fifo_byte", 32'(fifo_data_o), 32'(exp_q.pop_front()));
      end
    end
    if (frame_done_o === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (rd_o === 1'b0 && rd_prev === 1'b1) rd_cnt++;
    rd_prev = rd_o;
    if (cs_o === 1'b0 && cs_prev === 1'b1 && cs_fall_cyc < 0) cs_fall_cyc = cyc;
    cs_prev = cs_o;
  end

  task automatic check_reset_outputs();
    chk("rst_cs", 32'(cs_o), 32'd1);
    chk("rst_rd", 32'(rd_o), 32'd1);
    chk("rst_wrreq", 32'(fifo_wrreq_o), 32'd0);
    chk("rst_data", 32'(fifo_data_o), 32'h00);
    chk("rst_done", 32'(frame_done_o), 32'd0);
    chk("rst_overflow", 32'(overflow_o), 32'd0);
    chk("rst_err_frst", 32'(err_frst_o), 32'd0);
  endtask

  // One conversion: queue the expected frame, drop BUSY, watch it complete.
  task automatic run_frame(input int full_at, input bit glitch, input int rst_ch,
                           input bit check_lat);
    int  nexp;
    int  n;
    int  done0;
    bit  ended;
    logic [7:0] bytes[$];
    nexp  = (full_at < TOTAL) ? full_at : TOTAL;
    ended = 1'b0;
    if (HDR != 0) begin
      bytes.push_back(8'hA5);
      bytes.push_back(seq_m);
      seq_m = seq_m + 8'h01;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      bytes.push_back(adc_val[c][15:8]);
      bytes.push_back(adc_val[c][7:0]);
    end
    for (int b = 0; b < nexp; b++) exp_q.push_back(bytes[b]);
    if (full_at < TOTAL) ovf_m = 1'b1;
    if (frst_bad) err_m = 1'b1;

    adc_idx      = 0;
    frame_wr_cnt = 0;
    rd_cnt       = 0;
    cs_fall_cyc  = -1;
    done0        = done_cnt;
    busy_i       = 1'b1;
    repeat ($urandom_range(4, 8)) @(negedge clk_i);
    busy_i = 1'b0;

    if (check_lat) begin
      n = 0;
      for (int k = 0; k < 20; k++) begin
        @(posedge clk_i);
        #1;
        n++;
        if (cs_o === 1'b0) break;
      end
      chk("cs_low_edge", 32'(n), 32'(HDR + 3));
    end

    for (int i = 0; i < 400; i++) begin
      @(negedge clk_i);
      #1;
      if (frame_wr_cnt >= full_at) fifo_wrfull_i = 1'b1;
      if (glitch && i == 10) busy_i = 1'b1;
      if (glitch && i == 13) busy_i = 1'b0;
      if (rst_ch >= 0 && frame_wr_cnt == HDR + 2 * rst_ch && rd_o === 1'b0) begin
        #2;
        reset_n_i = 1'b0;
        #1;
        check_reset_outputs();
        exp_q.delete();
        ovf_m = 1'b0;
        err_m = 1'b0;
        seq_m = 8'h00;
        repeat (3) @(negedge clk_i);
        reset_n_i = 1'b1;
        repeat (20) @(negedge clk_i);
        chk("no_write_after_reset", 32'(frame_wr_cnt), 32'(HDR + 2 * rst_ch));
        chk("cs_idle_after_reset", 32'(cs_o), 32'd1);
        ended = 1'b1;
        break;
      end
      if (exp_q.size() == 0 && cs_o === 1'b1) begin
        ended = 1'b1;
        break;
      end
    end
    if (!ended) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout got %0d bytes required %0d", frame_wr_cnt, nexp);
      exp_q.delete();
    end
    if (rst_ch < 0) begin
      repeat (8) @(negedge clk_i);
      fifo_wrfull_i = 1'b0;
      chk("bytes_written", 32'(frame_wr_cnt), 32'(nexp));
      chk("frame_done_cnt", 32'(done_cnt - done0), (full_at >= TOTAL) ? 32'd1 : 32'd0);
      chk("overflow", 32'(overflow_o), 32'(ovf_m));
      chk("err_frst", 32'(err_frst_o), 32'(err_m));
      if (full_at >= TOTAL) begin
        chk("rd_pulses", 32'(rd_cnt), 32'(NUM_CH));
        chk("frame_cycles", 32'(done_cyc - cs_fall_cyc), 32'(FRAME_CYC));
      end
    end
  endtask

  task automatic rand_vals();
    for (int c = 0; c < NUM_CH; c++) adc_val[c] = 16'($urandom);
  endtask

  initial begin
    for (int c = 0; c < NUM_CH; c++) adc_val[c] = 16'h1234 + 16'(c) * 16'h1000;
    #1 reset_n_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check_reset_outputs();
    reset_n_i = 1'b1;
    repeat (4) @(negedge clk_i);

    // Fixed 0x1234..0x8234 frame with latency and frame-length checks.
    run_frame(1000, 1'b0, -1, 1'b1);
    // Random data frames.
    for (int f = 0; f < 3; f++) begin
      rand_vals();
      run_frame(1000, 1'b0, -1, 1'b0);
    end
    // FIFO full before channel 3 MSB, then a complete frame with overflow sticky.
    rand_vals();
    run_frame(HDR + 6, 1'b0, -1, 1'b0);
    rand_vals();
    run_frame(1000, 1'b0, -1, 1'b0);
    // FIFO full at a random byte.
    rand_vals();
    run_frame($urandom_range(2, TOTAL - 1), 1'b0, -1, 1'b0);
    // FRSTDATA held low on channel 0.
    frst_bad = 1'b1;
    rand_vals();
    run_frame(1000, 1'b0, -1, 1'b0);
    frst_bad = 1'b0;
    // Reset during channel 4 RD_LO with BUSY still low.
    rand_vals();
    run_frame(1000, 1'b0, 4, 1'b0);
    rand_vals();
    run_frame(1000, 1'b0, -1, 1'b1);
`ifdef READOUT_PKT_HEADER_EN
    while (seq_m != 8'hFF) begin
      rand_vals();
      run_frame(1000, 1'b0, -1, 1'b0);
    end
`endif
    // Second BUSY fall mid-frame is ignored; header wraps FF -> 00 when enabled.
    rand_vals();
    run_frame(1000, 1'b1, -1, 1'b1);
    rand_vals();
    run_frame(1000, 1'b0, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
